// File: rtl/dtack_generator.sv
// dtack_generator: responder side of the 68000 bus cycle.
// Samples AS_L and the decoder selects, then terminates the cycle with DTACK_L
// after a per-region wait (or the DRAM controller's own acknowledge), or with
// BERR_L when the watchdog expires on a DRAM or unmapped cycle.
module dtack_generator #(
    parameter int unsigned ROM_WAIT    = 0,
    parameter int unsigned RAM_WAIT    = 1,
    parameter int unsigned IO_WAIT     = 2,
    parameter int unsigned CAN_WAIT    = 4,
    parameter int unsigned OFFBRD_WAIT = 6,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic Clk,
    input  logic Reset_H,
    input  logic AS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic DramSelect_H,
    input  logic IOSelect_H,
    input  logic CanBusSelect_H,
    input  logic OffBoardMemory_H,
    input  logic DramDtack_L,
    output logic DTACK_L,
    output logic BERR_L,
    output logic Timeout_H
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_EXTWAIT = 3'd2,
        ST_ACK     = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ROM_W     = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_W     = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_W      = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] CAN_W     = CNT_W'(CAN_WAIT);
    localparam logic [CNT_W-1:0] OFFBRD_W  = CNT_W'(OFFBRD_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             is_dram_r, is_dram_next_s;
    logic             armed_r, armed_next_s;
    logic             internal_s, dram_s;
    logic [CNT_W-1:0] wait_load_s;
    logic             dtack_next_s, berr_next_s, timeout_next_s;

    // Region decode with fixed priority ROM > RAM > DRAM > IO > CAN > OFFBRD.
    always_comb begin
        internal_s  = 1'b0;
        dram_s      = 1'b0;
        wait_load_s = CNT_ZERO;
        if (OnChipRomSelect_H) begin
            internal_s  = 1'b1;
            wait_load_s = ROM_W;
        end else if (OnChipRamSelect_H) begin
            internal_s  = 1'b1;
            wait_load_s = RAM_W;
        end else if (DramSelect_H) begin
            dram_s = 1'b1;
        end else if (IOSelect_H) begin
            internal_s  = 1'b1;
            wait_load_s = IO_W;
        end else if (CanBusSelect_H) begin
            internal_s  = 1'b1;
            wait_load_s = CAN_W;
        end else if (OffBoardMemory_H) begin
            internal_s  = 1'b1;
            wait_load_s = OFFBRD_W;
        end else begin
            internal_s = 1'b0;
        end
    end

    // State, counter, latched region and re-arm flag registers.
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            is_dram_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            is_dram_r <= is_dram_next_s;
            armed_r   <= armed_next_s;
        end
    end

    // Next-state and counter logic; a cycle starts only after AS_L was seen high.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        is_dram_next_s = is_dram_r;
        if (AS_L) begin
            armed_next_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            armed_next_s = 1'b0;
        end else begin
            armed_next_s = armed_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (!AS_L && armed_r) begin
                    is_dram_next_s = dram_s;
                    if (internal_s) begin
                        cnt_next_s   = wait_load_s;
                        state_next_s = ST_WAIT;
                    end else begin
                        cnt_next_s   = CNT_ZERO;
                        state_next_s = ST_EXTWAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (AS_L) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_ACK;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_EXTWAIT: begin
                if (AS_L) begin
                    state_next_s = ST_IDLE;
                end else if (is_dram_r && !DramDtack_L) begin
                    state_next_s = ST_ACK;
                end else if (cnt_r == TIMEOUT_C) begin
                    state_next_s = ST_ERR;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACK, ST_ERR: begin
                if (AS_L) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so the pins change on the transition edge.
    always_comb begin
        dtack_next_s   = (state_next_s != ST_ACK);
        berr_next_s    = (state_next_s != ST_ERR);
        timeout_next_s = (state_r == ST_EXTWAIT) && (state_next_s == ST_ERR);
    end

    // Output flops driving the CPU pins directly.
    always_ff @(posedge Clk or posedge Reset_H) begin
        if (Reset_H) begin
            DTACK_L   <= 1'b1;
            BERR_L    <= 1'b1;
            Timeout_H <= 1'b0;
        end else begin
            DTACK_L   <= dtack_next_s;
            BERR_L    <= berr_next_s;
            Timeout_H <= timeout_next_s;
        end
    end

endmodule

// File: tb/tb_dtack_generator.sv
// Scoreboard bench for dtack_generator: stimulus pushes the expected output
// transitions (edge index + {DTACK_L,BERR_L,Timeout_H}); a monitor pops one
// entry every time the output vector changes and compares edge and value.
module tb_dtack_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic as_l = 1'b1;
    logic rom = 1'b0, ram = 1'b0, dram = 1'b0, io = 1'b0, can = 1'b0, offb = 1'b0;
    logic dram_dtack_l = 1'b1;
    logic dtack_l, berr_l, timeout_h;

    typedef struct {
        int         e;
        logic [2:0] v;
        string      nm;
    } ev_t;

    ev_t  exp_q[$];
    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic mon_en = 1'b0;
    int   n;

    dtack_generator dut (
        .Clk               (clk),
        .Reset_H           (rst),
        .AS_L              (as_l),
        .OnChipRomSelect_H (rom),
        .OnChipRamSelect_H (ram),
        .DramSelect_H      (dram),
        .IOSelect_H        (io),
        .CanBusSelect_H    (can),
        .OffBoardMemory_H  (offb),
        .DramDtack_L       (dram_dtack_l),
        .DTACK_L           (dtack_l),
        .BERR_L            (berr_l),
        .Timeout_H         (timeout_h)
    );

    always #5 clk = ~clk;

    // Edge index: value seen at a negedge is the number of the preceding posedge.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: each change of the output vector consumes one expected event.
    initial begin
        logic [2:0] prev;
        logic [2:0] cur;
        ev_t        ev;
        prev = 3'b110;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {dtack_l, berr_l, timeout_h};
                if (cur !== prev) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_change edge=%0d got dtack/berr/to=%b", edge_cnt, cur);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev.e != edge_cnt || ev.v !== cur) begin
                            miscompares++;
                            $display("FAIL %s got edge=%0d val=%b, required edge=%0d val=%b",
                                     ev.nm, edge_cnt, cur, ev.e, ev.v);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    task automatic expect_ev(input int e, input logic [2:0] v, input string nm);
        ev_t ev;
        ev.e  = e;
        ev.v  = v;
        ev.nm = nm;
        exp_q.push_back(ev);
    endtask

    // Return at the negedge just before edge e, so inputs set now are sampled at edge e.
    task automatic goto(input int e);
        while (edge_cnt < e - 1) @(negedge clk);
    endtask

    task automatic check_now(input string nm, input logic [2:0] want);
        vectors++;
        if ({dtack_l, berr_l, timeout_h} !== want) begin
            miscompares++;
            $display("FAIL %s got %b, required %b", nm, {dtack_l, berr_l, timeout_h}, want);
        end
    endtask

    task automatic clear_sel();
        rom = 1'b0; ram = 1'b0; dram = 1'b0; io = 1'b0; can = 1'b0; offb = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_now("reset_state", 3'b110);
        rst    = 1'b0;
        mon_en = 1'b1;
        goto(edge_cnt + 3);

        // ROM, wait 0: ack at N+1, release at N+4
        rom = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 1, 3'b010, "rom_ack");
        expect_ev(n + 4, 3'b110, "rom_release");
        goto(n + 4); as_l = 1'b1; clear_sel();

        // IO, wait 2: ack at N+3; select changed to ROM mid-cycle must be ignored
        goto(n + 6);
        io = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 3, 3'b010, "io_ack");
        expect_ev(n + 5, 3'b110, "io_release");
        goto(n + 1); io = 1'b0; rom = 1'b1;
        goto(n + 5); as_l = 1'b1; clear_sel();

        // RAM, wait 1: ack at N+2; back-to-back start right after the release edge
        goto(n + 6);
        ram = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 2, 3'b010, "ram_ack");
        expect_ev(n + 3, 3'b110, "ram_release");
        goto(n + 3); as_l = 1'b1;
        goto(n + 4); ram = 1'b0; can = 1'b1; offb = 1'b1; as_l = 1'b0;

        // CAN over OFFBRD priority, wait 4: ack at N+5
        n = edge_cnt + 1;
        expect_ev(n + 5, 3'b010, "can_prio_ack");
        expect_ev(n + 6, 3'b110, "can_prio_release");
        goto(n + 6); as_l = 1'b1; clear_sel();

        // ROM over DRAM priority: ack at N+1 without DRAM acknowledge
        goto(n + 8);
        rom = 1'b1; dram = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 1, 3'b010, "rom_over_dram_ack");
        expect_ev(n + 2, 3'b110, "rom_over_dram_release");
        goto(n + 2); as_l = 1'b1; clear_sel();

        // DRAM: DramDtack_L low sampled at N+5 -> ack at N+5
        goto(n + 4);
        dram = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 5, 3'b010, "dram_ack");
        expect_ev(n + 7, 3'b110, "dram_release");
        goto(n + 5); dram_dtack_l = 1'b0;
        goto(n + 6); dram_dtack_l = 1'b1;
        goto(n + 7); as_l = 1'b1; clear_sel();

        // DRAM watchdog: BERR at N+256 with one-cycle Timeout_H
        goto(n + 9);
        dram = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 256, 3'b101, "dram_timeout");
        expect_ev(n + 257, 3'b100, "dram_timeout_pulse_end");
        expect_ev(n + 260, 3'b110, "dram_berr_release");
        goto(n + 260); as_l = 1'b1; clear_sel();

        // DRAM acknowledge on the timeout edge: ACK wins, no BERR/Timeout
        goto(n + 262);
        dram = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 256, 3'b010, "dram_ack_at_timeout");
        expect_ev(n + 258, 3'b110, "dram_ack_at_timeout_release");
        goto(n + 256); dram_dtack_l = 1'b0;
        goto(n + 257); dram_dtack_l = 1'b1;
        goto(n + 258); as_l = 1'b1; clear_sel();

        // Unmapped: DramDtack_L ignored, always ends in BERR
        goto(n + 260);
        as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 256, 3'b101, "unmapped_timeout");
        expect_ev(n + 257, 3'b100, "unmapped_pulse_end");
        expect_ev(n + 300, 3'b110, "unmapped_release");
        goto(n + 10); dram_dtack_l = 1'b0;
        goto(n + 12); dram_dtack_l = 1'b1;
        goto(n + 300); as_l = 1'b1;

        // CAN abort inside WAIT: no outputs; next ROM cycle acknowledged
        goto(n + 302);
        can = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        goto(n + 2); as_l = 1'b1; can = 1'b0;
        goto(n + 3); rom = 1'b1; as_l = 1'b0;
        expect_ev(n + 4, 3'b010, "rom_after_abort_ack");
        expect_ev(n + 6, 3'b110, "rom_after_abort_release");
        goto(n + 6); as_l = 1'b1; clear_sel();

        // Reset during ACK: DTACK_L released asynchronously, then no restart until AS_L toggles
        goto(n + 8);
        rom = 1'b1; as_l = 1'b0; n = edge_cnt + 1;
        expect_ev(n + 1, 3'b010, "pre_reset_ack");
        expect_ev(n + 3, 3'b110, "reset_in_ack");
        goto(n + 3);
        #2 rst = 1'b1;
        #1 check_now("async_reset_dtack", 3'b110);
        @(negedge clk);
        #1 rst = 1'b0;
        goto(n + 10); as_l = 1'b1;
        goto(n + 11); as_l = 1'b0;
        expect_ev(n + 12, 3'b010, "post_reset_ack");
        expect_ev(n + 14, 3'b110, "post_reset_release");
        goto(n + 14); as_l = 1'b1; clear_sel();

        goto(n + 20);
        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            ev_t ev;
            ev = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s missing, required edge=%0d val=%b", ev.nm, ev.e, ev.v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
